// File: rtl/pipeline_id_early_redirect.sv
// rtl/pipeline_id_early_redirect.sv - IF/ID register with early JAL/BTFN redirect and wrong-path squash
module pipeline_id_early_redirect #(
  parameter int unsigned SHADOW_DEPTH = 2,
  parameter bit          PREDICT_BTFN = 1'b1,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        flush_i,
  input  logic        valid_f_i,
  input  logic [31:0] instruction_f_i,
  input  logic [31:0] pc_f_i,
  output logic [31:0] instruction_d_o,
  output logic [31:0] pc_d_o,
  output logic        valid_d_o,
  output logic        predicted_d_o,
  output logic [31:0] redirection_d_o,
  output logic        taken_d_o,
  output logic [1:0]  drain_cnt_d_o
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [1:0]  DEPTH    = SHADOW_DEPTH[1:0];
  localparam logic [1:0]  DEPTH_M1 = DEPTH - 2'd1;

  typedef enum logic {IDLE, SHADOW} state_t;

  state_t      state_q, state_n;
  logic [1:0]  cnt_q, cnt_n;
  logic [31:0] inst_q, pc_q;
  logic        valid_q, issued_q;

  logic        is_jal, is_bback, redirects, taken, squash, capture;
  logic [31:0] imm_j, imm_b, target;

  // Decode the D-stage instruction and form the redirect target and request.
  always_comb begin
    is_jal    = (inst_q[6:0] == 7'b1101111);
    is_bback  = (inst_q[6:0] == 7'b1100011) & inst_q[31] & PREDICT_BTFN;
    redirects = is_jal | is_bback;
    imm_j     = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
    imm_b     = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
    target    = pc_q + (is_jal ? imm_j : imm_b);
    taken     = valid_q & redirects & ~issued_q & ~flush_i;
    squash    = (state_q == SHADOW) | taken;
    capture   = enable & valid_f_i;
  end

  // Next state and drain count: arm on a redirect, count down on each squashed fetch.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    if (flush_i) begin
      state_n = IDLE;
      cnt_n   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (taken) begin
            if (capture) begin
              cnt_n   = DEPTH_M1;
              state_n = (DEPTH_M1 != 2'd0) ? SHADOW : IDLE;
            end else begin
              cnt_n   = DEPTH;
              state_n = SHADOW;
            end
          end
        end
        SHADOW: begin
          if (capture) begin
            cnt_n = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
              state_n = IDLE;
            end
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 2'd0;
        end
      endcase
    end
  end

  // Shadow FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // IF/ID register; the issued flag keeps a stalled redirect from firing twice.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_q   <= NOP;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      if (enable) begin
        inst_q <= instruction_f_i;
        pc_q   <= pc_f_i;
      end
      if (flush_i) begin
        valid_q  <= 1'b0;
        issued_q <= 1'b0;
      end else begin
        if (enable) begin
          valid_q <= valid_f_i & ~squash;
        end
        if (taken) begin
          issued_q <= 1'b1;
        end else if (enable) begin
          issued_q <= 1'b0;
        end
      end
    end
  end

  assign instruction_d_o = inst_q;
  assign pc_d_o          = pc_q;
  assign valid_d_o       = valid_q;
  assign predicted_d_o   = valid_q & redirects;
  assign taken_d_o       = taken;
  assign redirection_d_o = taken ? target : 32'h0;
  assign drain_cnt_d_o   = (state_q == SHADOW) ? cnt_q : 2'd0;

endmodule

// File: tb/tb_pipeline_id_early_redirect.sv
// tb/tb_pipeline_id_early_redirect.sv - scoreboard bench for pipeline_id_early_redirect
module tb_pipeline_id_early_redirect;

  logic        clk = 1'b0;
  logic        resetn, enable, flush_i, valid_f_i;
  logic [31:0] instruction_f_i, pc_f_i;

  logic [31:0] a_inst, a_pc, a_redir, b_inst, b_pc, b_redir;
  logic        a_valid, a_pred, a_taken, b_valid, b_pred, b_taken;
  logic [1:0]  a_drain, b_drain;

  always #5 clk = ~clk;

  pipeline_id_early_redirect u_a (
    .clk(clk), .resetn(resetn), .enable(enable), .flush_i(flush_i),
    .valid_f_i(valid_f_i), .instruction_f_i(instruction_f_i), .pc_f_i(pc_f_i),
    .instruction_d_o(a_inst), .pc_d_o(a_pc), .valid_d_o(a_valid),
    .predicted_d_o(a_pred), .redirection_d_o(a_redir), .taken_d_o(a_taken),
    .drain_cnt_d_o(a_drain)
  );

  pipeline_id_early_redirect #(
    .SHADOW_DEPTH(3), .PREDICT_BTFN(1'b0), .RESET_PC(32'h0000_0100)
  ) u_b (
    .clk(clk), .resetn(resetn), .enable(enable), .flush_i(flush_i),
    .valid_f_i(valid_f_i), .instruction_f_i(instruction_f_i), .pc_f_i(pc_f_i),
    .instruction_d_o(b_inst), .pc_d_o(b_pc), .valid_d_o(b_valid),
    .predicted_d_o(b_pred), .redirection_d_o(b_redir), .taken_d_o(b_taken),
    .drain_cnt_d_o(b_drain)
  );

  typedef struct {
    logic [31:0] inst, pc, redir;
    logic        valid, pred, taken;
    logic [1:0]  drain;
  } exp_t;

  // Model D stage: the instruction is tracked by its kind (0 other, 1 JAL, 2 branch) and immediate.
  typedef struct {
    logic [31:0] inst, pc;
    int          kind, imm;
    bit          valid, issued;
    int          drain;
  } mst_t;

  typedef struct {
    bit          rn, en, vf, fl;
    logic [31:0] inst, pc;
    int          kind, imm;
  } stim_t;

  exp_t  q_a[$], q_b[$];
  mst_t  ma, mb;
  stim_t cur;
  int    checks = 0, errors = 0;
  bit    started = 1'b0;

  function automatic mst_t m_reset(logic [31:0] rpc);
    mst_t s;
    s.inst = 32'h0000_0013; s.pc = rpc; s.kind = 0; s.imm = 0;
    s.valid = 1'b0; s.issued = 1'b0; s.drain = 0;
    return s;
  endfunction

  function automatic bit m_redirects(mst_t s, bit btfn);
    return (s.kind == 1) || (s.kind == 2 && s.imm < 0 && btfn);
  endfunction

  function automatic exp_t m_out(mst_t s, bit fl, bit btfn);
    exp_t e;
    e.inst  = s.inst;
    e.pc    = s.pc;
    e.valid = s.valid;
    e.pred  = s.valid && m_redirects(s, btfn);
    e.taken = e.pred && !s.issued && !fl;
    e.redir = e.taken ? s.pc + 32'(s.imm) : 32'h0;
    e.drain = 2'(s.drain);
    return e;
  endfunction

  function automatic mst_t m_step(mst_t s, stim_t x, int depth, bit btfn, logic [31:0] rpc);
    mst_t n = s;
    bit   tk;
    if (!x.rn) return m_reset(rpc);
    tk = s.valid && m_redirects(s, btfn) && !s.issued && !x.fl;
    if (x.en) begin
      n.inst = x.inst; n.pc = x.pc; n.kind = x.kind; n.imm = x.imm;
    end
    if (x.fl) begin
      n.valid = 1'b0; n.issued = 1'b0; n.drain = 0;
    end else begin
      if (x.en) begin
        n.valid  = x.vf && !(s.drain > 0 || tk);
        n.issued = 1'b0;
      end
      if (tk) begin
        n.issued = 1'b1;
        n.drain  = depth - ((x.en && x.vf) ? 1 : 0);
      end else if (s.drain > 0 && x.en && x.vf) begin
        n.drain = s.drain - 1;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] enc_jal(int imm);
    logic [31:0] v = imm;
    logic [31:0] i = 32'h0;
    i[31] = v[20]; i[30:21] = v[10:1]; i[20] = v[11]; i[19:12] = v[19:12];
    i[11:7] = 5'd1; i[6:0] = 7'h6F;
    return i;
  endfunction

  function automatic logic [31:0] enc_b(int imm);
    logic [31:0] v = imm;
    logic [31:0] i = 32'h0;
    i[31] = v[12]; i[30:25] = v[10:5]; i[11:8] = v[4:1]; i[7] = v[11];
    i[24:15] = 10'($urandom); i[6:0] = 7'h63;
    return i;
  endfunction

  function automatic logic [31:0] enc_other();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 3))
      0: r[6:0] = 7'h13;
      1: r[6:0] = 7'h33;
      2: r[6:0] = 7'h03;
      default: r[6:0] = 7'h37;
    endcase
    return r;
  endfunction

  function automatic stim_t mk(bit rn, bit en, bit vf, bit fl, int kind, int imm, logic [31:0] pc);
    stim_t x;
    x.rn = rn; x.en = en; x.vf = vf; x.fl = fl; x.kind = kind; x.imm = imm; x.pc = pc;
    x.inst = (kind == 1) ? enc_jal(imm) : (kind == 2) ? enc_b(imm) : enc_other();
    return x;
  endfunction

  task automatic drive(stim_t x);
    @(posedge clk);
    ma = m_step(ma, cur, 2, 1'b1, 32'h0);
    mb = m_step(mb, cur, 3, 1'b0, 32'h0000_0100);
    #2;
    resetn = x.rn; enable = x.en; valid_f_i = x.vf; flush_i = x.fl;
    instruction_f_i = x.inst; pc_f_i = x.pc;
    cur = x;
    if (!x.rn) begin
      ma = m_reset(32'h0);
      mb = m_reset(32'h0000_0100);
    end
    q_a.push_back(m_out(ma, x.fl, 1'b1));
    q_b.push_back(m_out(mb, x.fl, 1'b0));
  endtask

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all(string tag, exp_t e, logic [31:0] inst, logic [31:0] pc, logic valid,
                         logic pred, logic taken, logic [31:0] redir, logic [1:0] drain);
    cmp({tag, "_instruction"}, inst, e.inst);
    cmp({tag, "_pc"}, pc, e.pc);
    cmp({tag, "_valid"}, 32'(valid), 32'(e.valid));
    cmp({tag, "_predicted"}, 32'(pred), 32'(e.pred));
    cmp({tag, "_taken"}, 32'(taken), 32'(e.taken));
    cmp({tag, "_redirection"}, redir, e.redir);
    cmp({tag, "_drain_cnt"}, 32'(drain), 32'(e.drain));
  endtask

  // Monitor: pop one expected record per instance each cycle and compare away from the edge.
  initial begin
    exp_t ea, eb;
    forever begin
      @(negedge clk);
      if (started) begin
        if (q_a.size() == 0 || q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty actual=%0d required=1", q_a.size());
        end else begin
          ea = q_a.pop_front();
          eb = q_b.pop_front();
          cmp_all("a", ea, a_inst, a_pc, a_valid, a_pred, a_taken, a_redir, a_drain);
          cmp_all("b", eb, b_inst, b_pc, b_valid, b_pred, b_taken, b_redir, b_drain);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    int kind, imm;
    resetn = 1'b0; enable = 1'b0; flush_i = 1'b0; valid_f_i = 1'b0;
    instruction_f_i = 32'h0000_0013; pc_f_i = 32'h0;
    cur = mk(0, 0, 0, 0, 0, 0, 32'h0);
    ma = m_reset(32'h0);
    mb = m_reset(32'h0000_0100);
    started = 1'b1;

    drive(mk(0, 0, 0, 0, 0, 0, 32'h0));
    drive(mk(0, 1, 1, 0, 0, 0, 32'h0));
    drive(mk(1, 0, 0, 0, 0, 0, 32'h0));

    // JAL +0x20 at 0x10 followed by its wrong path and the target.
    drive(mk(1, 1, 1, 0, 1, 32'h20, 32'h10));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h14));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h18));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h1C));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h30));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h34));

    // Same JAL held by a three-cycle stall.
    drive(mk(1, 1, 1, 0, 1, 32'h20, 32'h10));
    for (int i = 0; i < 3; i++) drive(mk(1, 0, 1, 0, 0, 0, 32'h14));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h14));
    drive(mk(1, 1, 0, 0, 0, 0, 32'h18));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h18));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h1C));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h30));

    // Backward BEQ -8 at 0x40, then forward BEQ +8.
    drive(mk(1, 1, 1, 0, 2, -8, 32'h40));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h44));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h48));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h4C));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h38));
    drive(mk(1, 1, 1, 0, 2, 8, 32'h3C));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h40));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h44));

    // Flush while one wrong-path fetch is still pending.
    drive(mk(1, 1, 1, 0, 1, 32'h20, 32'h10));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h14));
    drive(mk(1, 1, 1, 1, 0, 0, 32'h18));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h30));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h34));

    // Flush in the same cycle the JAL sits in D.
    drive(mk(1, 1, 1, 0, 1, 32'h20, 32'h10));
    drive(mk(1, 1, 1, 1, 0, 0, 32'h14));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h50));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h54));

    // Reset pulse in the middle of the shadow.
    drive(mk(1, 1, 1, 0, 1, 32'h20, 32'h10));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h14));
    drive(mk(0, 1, 1, 0, 0, 0, 32'h18));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h0));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h4));
    drive(mk(1, 1, 1, 0, 0, 0, 32'h8));

    // Random traffic.
    pc = 32'h1000;
    for (int n = 0; n < 800; n++) begin
      kind = $urandom_range(0, 9);
      kind = (kind < 5) ? 0 : (kind < 7) ? 1 : 2;
      if (kind == 1) imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      else if (kind == 2) imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
      else imm = 0;
      drive(mk($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 85,
               $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 5, kind, imm, pc));
      pc = pc + 32'd4;
    end

    @(negedge clk);
    #1;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q_a.size() + q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
